// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU write scheduler
package ppu_pkg;
  typedef enum logic [1:0] {WAIT_BLANK = 2'd0, DRAIN = 2'd1, DONE = 2'd2} sched_state_t;
  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
  } ppu_wr_t;
  localparam logic [2:0] CTRL_ADDR = 3'd7;
endpackage

// File: rtl/ppu_write_scheduler_if.sv
// ppu_write_scheduler_if: Avalon write port in, committed sprite-register word out
interface ppu_write_scheduler_if;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic        commit_valid;
  logic [2:0]  commit_addr;
  logic [31:0] commit_data;
  modport master (output chipselect, write, address, writedata, input commit_valid, commit_addr, commit_data);
  modport slave (input chipselect, write, address, writedata, output commit_valid, commit_addr, commit_data);
endinterface

// File: rtl/ppu_wr_fifo.sv
// ppu_wr_fifo: synchronous FIFO of queued register writes; flush empties it and masks any pop
module ppu_wr_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  ppu_wr_t       i_din,
  input  logic          i_pop,
  input  logic          i_flush,
  output ppu_wr_t       o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  ppu_wr_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  // storage array, written at the tail
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
  // pointers wrap naturally at DEPTH; flush drops everything by snapping read to write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= r_wr;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/ppu_write_scheduler.sv
// ppu_write_scheduler: queues host writes and releases them to the sprite modules only during vblank
module ppu_write_scheduler
  import ppu_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int VACTIVE     = 480,
  parameter int VTOTAL      = 525,
  parameter int MAX_COMMITS = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(MAX_COMMITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  ppu_write_scheduler_if.slave  bus,
  input  logic [9:0]            vcount,
  output logic [AW:0]           fifo_count,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic                  frame_tick,
  output logic [1:0]            state_dbg
);
  sched_state_t r_state;
  logic [CW-1:0] r_commits;
  logic          r_vblank_q;
  logic          r_frame_tick;
  logic          r_overflow;
  logic          r_commit_valid;
  logic [2:0]    r_commit_addr;
  logic [31:0]   r_commit_data;
  logic          w_vblank;
  logic          w_blank_rise;
  logic          w_wr;
  logic          w_ctrl;
  logic          w_push;
  logic          w_flush;
  logic          w_pop;
  logic          w_stop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [AW:0]   w_next_count;
  ppu_wr_t       w_dout;
  assign w_vblank     = (vcount >= 10'(VACTIVE)) && (vcount < 10'(VTOTAL));
  assign w_blank_rise = w_vblank & ~r_vblank_q;
  assign w_wr         = bus.chipselect & bus.write;
  assign w_ctrl       = w_wr & (bus.address == CTRL_ADDR);
  assign w_push       = w_wr & ~w_ctrl;
  assign w_flush      = w_ctrl & bus.writedata[1];
  assign w_pop        = (r_state == DRAIN) & ~w_empty & ~w_flush & (r_commits < CW'(MAX_COMMITS));
  assign w_next_count = w_flush ? '0 : w_count + (AW+1)'(w_push & ~w_full) - (AW+1)'(w_pop);
  assign w_stop       = (w_next_count == '0) | ((r_commits + CW'(w_pop)) == CW'(MAX_COMMITS)) | ~w_vblank;
  ppu_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_din   ({bus.address, bus.writedata}),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // vblank edge detect, registered commit port and sticky overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vblank_q     <= 1'b0;
      r_frame_tick   <= 1'b0;
      r_overflow     <= 1'b0;
      r_commit_valid <= 1'b0;
      r_commit_addr  <= '0;
      r_commit_data  <= '0;
    end else begin
      r_vblank_q     <= w_vblank;
      r_frame_tick   <= w_blank_rise;
      r_overflow     <= (w_push & w_full) | (r_overflow & ~(w_ctrl & bus.writedata[0]));
      r_commit_valid <= w_pop;
      if (w_pop) {r_commit_addr, r_commit_data} <= w_dout;
    end
  // frame scheduler: wait for vblank, drain within budget, then hold until active video resumes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= WAIT_BLANK;
      r_commits <= '0;
    end else begin
      case (r_state)
        WAIT_BLANK: if (w_blank_rise) begin
          r_state   <= DRAIN;
          r_commits <= '0;
        end
        DRAIN: begin
          r_commits <= r_commits + CW'(w_pop);
          if (w_stop) r_state <= DONE;
        end
        DONE: if (!w_vblank) r_state <= WAIT_BLANK;
        default: r_state <= WAIT_BLANK;
      endcase
    end
  assign fifo_count       = w_count;
  assign fifo_full        = w_full;
  assign overflow         = r_overflow;
  assign frame_tick       = r_frame_tick;
  assign state_dbg        = r_state;
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_addr  = r_commit_addr;
  assign bus.commit_data  = r_commit_data;
endmodule

// File: tb/tb_ppu_write_scheduler.sv
// tb_ppu_write_scheduler: directed vectors and frame sequences for the vblank write scheduler
module tb_ppu_write_scheduler;
  import ppu_pkg::*;
  typedef struct {
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    int          cnt;
    logic        full;
    logic        ovf;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  vcount;
  logic [4:0]  fifo_count;
  logic        fifo_full;
  logic        overflow;
  logic        frame_tick;
  logic [1:0]  state_dbg;
  int          checks = 0;
  int          failures = 0;
  int          ticks;
  logic [34:0] got[$];
  vec_t        tbl[20];
  ppu_write_scheduler_if bus();
  ppu_write_scheduler #(.DEPTH(16), .VACTIVE(480), .VTOTAL(525), .MAX_COMMITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .vcount     (vcount),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .frame_tick (frame_tick),
    .state_dbg  (state_dbg)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic cs, input logic we, input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = cs;
    bus.write      = we;
    bus.address    = a;
    bus.writedata  = d;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
    step();
    drive(1'b0, 1'b0, 3'd0, 32'd0);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (frame_tick) ticks++;
      if (bus.commit_valid) got.push_back({bus.commit_addr, bus.commit_data});
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " count"}, 64'(fifo_count), 64'd0);
    chk({tag, " full"}, 64'(fifo_full), 64'd0);
    chk({tag, " ovf"}, 64'(overflow), 64'd0);
    chk({tag, " tick"}, 64'(frame_tick), 64'd0);
    chk({tag, " state"}, 64'(state_dbg), 64'd0);
    chk({tag, " cv"}, 64'(bus.commit_valid), 64'd0);
    chk({tag, " caddr"}, 64'(bus.commit_addr), 64'd0);
    chk({tag, " cdata"}, 64'(bus.commit_data), 64'd0);
  endtask
  task automatic idle();
    vcount = 10'd100;
    step();
    step();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].cs = 1'b1; tbl[i].we = 1'b1; tbl[i].addr = 3'(i % 7); tbl[i].data = 32'hC000 + 32'(i);
      tbl[i].cnt = i + 1; tbl[i].full = (i == 15); tbl[i].ovf = 1'b0;
    end
    tbl[16] = '{cs: 1'b1, we: 1'b1, addr: 3'd0, data: 32'hDEAD, cnt: 16, full: 1'b1, ovf: 1'b1};
    tbl[17] = '{cs: 1'b1, we: 1'b0, addr: 3'd1, data: 32'hBEEF, cnt: 16, full: 1'b1, ovf: 1'b1};
    tbl[18] = '{cs: 1'b1, we: 1'b1, addr: 3'd7, data: 32'd1, cnt: 16, full: 1'b1, ovf: 1'b0};
    tbl[19] = '{cs: 1'b1, we: 1'b1, addr: 3'd7, data: 32'd2, cnt: 0, full: 1'b0, ovf: 1'b0};
    reset = 1'b1;
    vcount = 10'd0;
    drive(1'b0, 1'b0, 3'd0, 32'd0);
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) wr(3'(i), 32'h1234 + 32'(i));
    chk("t1 count", 64'(fifo_count), 64'd3);
    chk("t1 cv idle", 64'(bus.commit_valid), 64'd0);
    vcount = 10'd480;
    step();
    chk("t1 tick", 64'(frame_tick), 64'd1);
    chk("t1 drain", 64'(state_dbg), 64'd1);
    chk("t1 cv early", 64'(bus.commit_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1 cv", 64'(bus.commit_valid), 64'd1);
      chk("t1 word", 64'({bus.commit_addr, bus.commit_data}), 64'({3'(k), 32'h1234 + 32'(k)}));
      chk("t1 tick low", 64'(frame_tick), 64'd0);
    end
    chk("t1 done", 64'(state_dbg), 64'd2);
    chk("t1 empty", 64'(fifo_count), 64'd0);
    step();
    chk("t1 cv end", 64'(bus.commit_valid), 64'd0);
    chk("t1 hold", 64'(bus.commit_data), 64'h1236);
    idle();
    chk("t1 wait", 64'(state_dbg), 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].cs, tbl[i].we, tbl[i].addr, tbl[i].data);
      step();
      chk($sformatf("vec%0d count", i), 64'(fifo_count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d full", i), 64'(fifo_full), 64'(tbl[i].full));
      chk($sformatf("vec%0d ovf", i), 64'(overflow), 64'(tbl[i].ovf));
    end
    drive(1'b0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 10; i++) wr(3'(i % 7), 32'hB000 + 32'(i));
    for (int f = 0; f < 3; f++) begin
      ticks = 0;
      got.delete();
      vcount = 10'd480;
      run(8);
      chk("t3 tick", 64'(ticks), 64'd1);
      chk("t3 n", 64'(got.size()), (f < 2) ? 64'd4 : 64'd2);
      for (int k = 0; k < got.size(); k++)
        chk("t3 word", 64'(got[k]), 64'({3'((f * 4 + k) % 7), 32'hB000 + 32'(f * 4 + k)}));
      chk("t3 done", 64'(state_dbg), 64'd2);
      chk("t3 left", 64'(fifo_count), (f < 2) ? 64'(6 - f * 4) : 64'd0);
      idle();
    end
    vcount = 10'd480;
    step();
    chk("t4 drain", 64'(state_dbg), 64'd1);
    wr(3'd2, 32'hA5A5_0000);
    chk("t4 stay", 64'(state_dbg), 64'd1);
    chk("t4 cv n1", 64'(bus.commit_valid), 64'd0);
    step();
    chk("t4 cv n2", 64'(bus.commit_valid), 64'd1);
    chk("t4 word", 64'({bus.commit_addr, bus.commit_data}), 64'({3'd2, 32'hA5A5_0000}));
    chk("t4 done", 64'(state_dbg), 64'd2);
    idle();
    for (int i = 0; i < 3; i++) wr(3'd3, 32'hE000 + 32'(i));
    vcount = 10'd480;
    step();
    step();
    chk("t5 word0", 64'({bus.commit_valid, bus.commit_data}), 64'({1'b1, 32'hE000}));
    vcount = 10'd0;
    step();
    chk("t5 word1", 64'({bus.commit_valid, bus.commit_data}), 64'({1'b1, 32'hE001}));
    chk("t5 done", 64'(state_dbg), 64'd2);
    step();
    chk("t5 wait", 64'(state_dbg), 64'd0);
    chk("t5 cv", 64'(bus.commit_valid), 64'd0);
    chk("t5 kept", 64'(fifo_count), 64'd1);
    wr(3'd7, 32'd2);
    idle();
    for (int i = 0; i < 5; i++) wr(3'd4, 32'h5000 + 32'(i));
    chk("t6 count", 64'(fifo_count), 64'd5);
    wr(3'd7, 32'd2);
    chk("t6 flushed", 64'(fifo_count), 64'd0);
    vcount = 10'd480;
    step();
    chk("t6 drain", 64'(state_dbg), 64'd1);
    step();
    chk("t6 done", 64'(state_dbg), 64'd2);
    ticks = 0;
    got.delete();
    run(4);
    chk("t6 none", 64'(got.size()), 64'd0);
    idle();
    for (int i = 0; i < 8; i++) wr(3'd5, 32'hF000 + 32'(i));
    vcount = 10'd480;
    step();
    step();
    chk("t7 word0", 64'({bus.commit_valid, bus.commit_data}), 64'({1'b1, 32'hF000}));
    step();
    chk("t7 word1", 64'({bus.commit_valid, bus.commit_data}), 64'({1'b1, 32'hF001}));
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    vcount = 10'd100;
    step();
    reset = 1'b0;
    step();
    ticks = 0;
    got.delete();
    vcount = 10'd480;
    run(6);
    chk("t7 tick", 64'(ticks), 64'd1);
    chk("t7 none", 64'(got.size()), 64'd0);
    chk("t7 done", 64'(state_dbg), 64'd2);
    chk("t7 count", 64'(fifo_count), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
